// File: rtl/axis_fifo_pkt.sv
// axis_fifo_pkt: synchronous AXI-Stream FIFO with per-word TLAST, fill level,
// almost-full and optional store-and-forward packet mode.
//
// Storage is a (DEPTH-1)-entry RAM plus one output register driving M_AXIS_*.
//
// Ports:
//   clk, rst_n                     clock (rising edge), async active-low reset
//   S_AXIS_TVALID/TREADY/TDATA/TLAST  slave (input) stream
//   M_AXIS_TVALID/TREADY/TDATA/TLAST  master (output) stream
//   level                          words held (RAM + output register)
//   almost_full                    level >= AFULL_LEVEL
//   pkt_count                      TLAST words held
module axis_fifo_pkt #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned PACKET_MODE = 0,
  parameter int unsigned AFULL_LEVEL = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    S_AXIS_TVALID,
  output logic                    S_AXIS_TREADY,
  input  logic [DATA_WIDTH-1:0]   S_AXIS_TDATA,
  input  logic                    S_AXIS_TLAST,
  output logic                    M_AXIS_TVALID,
  input  logic                    M_AXIS_TREADY,
  output logic [DATA_WIDTH-1:0]   M_AXIS_TDATA,
  output logic                    M_AXIS_TLAST,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    almost_full,
  output logic [$clog2(DEPTH):0]  pkt_count
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam int unsigned LW       = AW + 1;
  localparam int unsigned RamDepth = DEPTH - 1;
  localparam logic [AW-1:0] LastIdx = AW'(DEPTH - 2);

  logic [DATA_WIDTH:0] mem_q [RamDepth];

  logic [AW-1:0]         wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
  logic                  wr_wrap_q, wr_wrap_d, rd_wrap_q, rd_wrap_d;
  logic [LW-1:0]         level_q, level_d, pkt_count_q, pkt_count_d;
  logic                  s_ready_q, s_ready_d;
  logic                  out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  escape_q, escape_d;

  logic                  push, pop, out_free, ram_empty, ram_full;
  logic                  esc_trig, esc_ok, head_ok, byp_ok;
  logic                  load_ram, load_byp, ram_wr;
  logic [LW-1:0]         ram_pkts;
  logic [DATA_WIDTH:0]   head;

  assign push      = S_AXIS_TVALID && s_ready_q;
  assign pop       = out_valid_q && M_AXIS_TREADY;
  assign out_free  = !out_valid_q || pop;
  assign ram_empty = (wr_idx_q == rd_idx_q) && (wr_wrap_q == rd_wrap_q);
  assign ram_full  = (wr_idx_q == rd_idx_q) && (wr_wrap_q != rd_wrap_q);
  assign head      = mem_q[rd_idx_q];

  // Packets whose TLAST sits in the RAM; the head word's packet is complete iff nonzero.
  assign ram_pkts  = pkt_count_q - LW'(out_valid_q && out_last_q);

  // Oversize escape: RAM full with no complete packet would deadlock, so stream it out.
  assign esc_trig  = (PACKET_MODE != 0) && ram_full && (pkt_count_q == '0);
  // Escape covers only the oversize packet: stop once its TLAST reaches the output.
  assign esc_ok    = escape_q && !(out_valid_q && out_last_q);

  always_comb begin
    head_ok  = (PACKET_MODE == 0) || esc_trig || esc_ok || (ram_pkts != '0);
    byp_ok   = (PACKET_MODE == 0) || esc_ok;
    load_ram = out_free && !ram_empty && head_ok;
    load_byp = out_free && ram_empty && push && byp_ok;
    ram_wr   = push && !load_byp;
  end

  always_comb begin
    wr_idx_d  = wr_idx_q;
    wr_wrap_d = wr_wrap_q;
    if (ram_wr) begin
      if (wr_idx_q == LastIdx) begin
        wr_idx_d  = '0;
        wr_wrap_d = ~wr_wrap_q;
      end else begin
        wr_idx_d  = wr_idx_q + 1'b1;
      end
    end
    rd_idx_d  = rd_idx_q;
    rd_wrap_d = rd_wrap_q;
    if (load_ram) begin
      if (rd_idx_q == LastIdx) begin
        rd_idx_d  = '0;
        rd_wrap_d = ~rd_wrap_q;
      end else begin
        rd_idx_d  = rd_idx_q + 1'b1;
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    if (load_ram) begin
      out_valid_d = 1'b1;
      out_data_d  = head[DATA_WIDTH-1:0];
      out_last_d  = head[DATA_WIDTH];
    end else if (load_byp) begin
      out_valid_d = 1'b1;
      out_data_d  = S_AXIS_TDATA;
      out_last_d  = S_AXIS_TLAST;
    end else if (pop) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  always_comb begin
    level_d     = level_q + LW'(push) - LW'(pop);
    pkt_count_d = pkt_count_q + LW'(push && S_AXIS_TLAST) - LW'(pop && out_last_q);
    s_ready_d   = (level_d != LW'(DEPTH));
    escape_d    = escape_q;
    if (pop && out_last_q) begin
      escape_d = 1'b0;
    end else if (esc_trig) begin
      escape_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_wr) begin
      mem_q[wr_idx_q] <= {S_AXIS_TLAST, S_AXIS_TDATA};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx_q    <= '0;
      wr_wrap_q   <= 1'b0;
      rd_idx_q    <= '0;
      rd_wrap_q   <= 1'b0;
      level_q     <= '0;
      pkt_count_q <= '0;
      s_ready_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      escape_q    <= 1'b0;
    end else begin
      wr_idx_q    <= wr_idx_d;
      wr_wrap_q   <= wr_wrap_d;
      rd_idx_q    <= rd_idx_d;
      rd_wrap_q   <= rd_wrap_d;
      level_q     <= level_d;
      pkt_count_q <= pkt_count_d;
      s_ready_q   <= s_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      escape_q    <= escape_d;
    end
  end

  assign S_AXIS_TREADY = s_ready_q;
  assign M_AXIS_TVALID = out_valid_q;
  assign M_AXIS_TDATA  = out_data_q;
  assign M_AXIS_TLAST  = out_last_q;
  assign level         = level_q;
  assign pkt_count     = pkt_count_q;
  assign almost_full   = (level_q >= LW'(AFULL_LEVEL));

endmodule
